// File: rtl/serial_word_loader.sv
// ============================================================================
// serial_word_loader : framed serial-to-parallel word assembler with load strobe
// Optional even-parity check: define SERIAL_WORD_LOADER_PARITY_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module serial_word_loader #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clock,
    input  logic         resetN,
    input  logic         sync_clear,
    input  logic         frame_start,
    input  logic         ser_valid,
    input  logic         ser_data,
    output logic         word_en,
    output logic [N-1:0] word,
    output logic         busy,
    output logic         frame_err,
    output logic         parity_err
);

    localparam int            CW         = $clog2(N + 1);
    localparam logic [CW-1:0] c_LAST     = CW'(N - 1);
    localparam logic [1:0]    c_ST_IDLE  = 2'd0;
    localparam logic [1:0]    c_ST_SHIFT = 2'd1;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
    localparam logic [1:0]    c_ST_PARITY = 2'd2;
`endif

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  shift_q, shift_d;
    logic [N-1:0]  word_q, word_d;
    logic          word_en_q, word_en_d;
    logic          frame_err_q, frame_err_d;
    logic [N-1:0]  w_shift_next;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
    logic          parity_err_q, parity_err_d;
`endif

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shift_next = {shift_q[N-2:0], ser_data};
        end else begin : g_lsb_first
            assign w_shift_next = {ser_data, shift_q[N-1:1]};
        end
    endgenerate

    // State and datapath registers
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q      <= c_ST_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            word_q       <= '0;
            word_en_q    <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            word_en_q    <= word_en_d;
            frame_err_q  <= frame_err_d;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Next state: sync_clear beats frame_start, which beats data acceptance
    always_comb begin
        state_d = state_q;
        if (sync_clear) begin
            state_d = c_ST_IDLE;
        end else if (frame_start) begin
            state_d = c_ST_SHIFT;
        end else if (ser_valid) begin
            case (state_q)
                c_ST_SHIFT: begin
                    if (cnt_q == c_LAST) begin
`ifdef SERIAL_WORD_LOADER_PARITY_EN
                        state_d = c_ST_PARITY;
`else
                        state_d = c_ST_IDLE;
`endif
                    end
                end
`ifdef SERIAL_WORD_LOADER_PARITY_EN
                c_ST_PARITY: state_d = c_ST_IDLE;
`endif
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath and strobe next values
    always_comb begin
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        word_d       = word_q;
        word_en_d    = 1'b0;
        frame_err_d  = 1'b0;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
        parity_err_d = 1'b0;
`endif
        if (sync_clear) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (frame_start) begin
            cnt_d       = '0;
            shift_d     = '0;
            frame_err_d = (state_q != c_ST_IDLE);
        end else if (ser_valid) begin
            case (state_q)
                c_ST_SHIFT: begin
                    shift_d = w_shift_next;
                    if (cnt_q == c_LAST) begin
                        cnt_d = '0;
`ifndef SERIAL_WORD_LOADER_PARITY_EN
                        word_d    = w_shift_next;
                        word_en_d = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
`ifdef SERIAL_WORD_LOADER_PARITY_EN
                c_ST_PARITY: begin
                    shift_d = '0;
                    if (^{shift_q, ser_data}) begin
                        parity_err_d = 1'b1;
                    end else begin
                        word_d    = shift_q;
                        word_en_d = 1'b1;
                    end
                end
`endif
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Outputs: all decoded from registers only
    always_comb begin
        word_en    = word_en_q;
        word       = word_q;
        busy       = (state_q != c_ST_IDLE);
        frame_err  = frame_err_q;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
        parity_err = parity_err_q;
`else
        parity_err = 1'b0;
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_word_loader.sv
// ============================================================================
// tb_serial_word_loader : directed bench driving an MSB-first and an LSB-first
// instance with identical serial streams.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_word_loader;

    logic       clock = 1'b0;
    logic       resetN, sync_clear, frame_start, ser_valid, ser_data;
    logic       word_en_m, busy_m, frame_err_m, parity_err_m;
    logic       word_en_l, busy_l, frame_err_l, parity_err_l;
    logic [7:0] word_m, word_l;

    int tests = 0;
    int fails = 0;
    int en_m, en_l, ferr_m, ferr_l, perr_m;

    always #5 clock = ~clock;

    serial_word_loader #(.N(8), .MSB_FIRST(1'b1)) u_msb (
        .clock(clock), .resetN(resetN), .sync_clear(sync_clear),
        .frame_start(frame_start), .ser_valid(ser_valid), .ser_data(ser_data),
        .word_en(word_en_m), .word(word_m), .busy(busy_m),
        .frame_err(frame_err_m), .parity_err(parity_err_m)
    );

    serial_word_loader #(.N(8), .MSB_FIRST(1'b0)) u_lsb (
        .clock(clock), .resetN(resetN), .sync_clear(sync_clear),
        .frame_start(frame_start), .ser_valid(ser_valid), .ser_data(ser_data),
        .word_en(word_en_l), .word(word_l), .busy(busy_l),
        .frame_err(frame_err_l), .parity_err(parity_err_l)
    );

    typedef struct {
        logic [7:0] bits;
        int         gap_max;
        bit         idle_after;
        logic [7:0] exp_m;
        logic [7:0] exp_l;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic zero_counts();
        en_m = 0; en_l = 0; ferr_m = 0; ferr_l = 0; perr_m = 0;
    endtask

    // One clock: sample 1 time unit after the rising edge and tally strobes
    task automatic step();
        @(posedge clock);
        #1;
        if (word_en_m)    en_m++;
        if (word_en_l)    en_l++;
        if (frame_err_m)  ferr_m++;
        if (frame_err_l)  ferr_l++;
        if (parity_err_m) perr_m++;
    endtask

    // Sends seq[nbits-1] first; the bit offered with frame_start must be ignored
    task automatic send_bits(input logic [8:0] seq, input int nbits, input int gap_max,
                             input bit do_start);
        int g;
        if (do_start) begin
            frame_start = 1'b1; ser_valid = 1'b1; ser_data = 1'b1;
            step();
            frame_start = 1'b0;
        end
        for (int i = nbits - 1; i >= 0; i--) begin
            g = int'($urandom_range(gap_max, 0));
            repeat (g) begin
                ser_valid = 1'b0; ser_data = 1'($urandom);
                step();
            end
            ser_valid = 1'b1; ser_data = seq[i];
            step();
        end
        ser_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] bits, input int gap_max, input bit do_start);
`ifdef SERIAL_WORD_LOADER_PARITY_EN
        send_bits({bits, ^bits}, 9, gap_max, do_start);
`else
        send_bits({1'b0, bits}, 8, gap_max, do_start);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{8'hA5, 0, 1'b1, 8'hA5, 8'hA5};
        vecs[1] = '{8'hA5, 5, 1'b1, 8'hA5, 8'hA5};
        vecs[2] = '{8'hC8, 2, 1'b0, 8'hC8, 8'h13};
        vecs[3] = '{8'h5B, 0, 1'b0, 8'h5B, 8'hDA};
        vecs[4] = '{8'h01, 3, 1'b1, 8'h01, 8'h80};
        vecs[5] = '{8'hFE, 0, 1'b1, 8'hFE, 8'h7F};

        resetN = 1'b0; sync_clear = 1'b0; frame_start = 1'b0;
        ser_valid = 1'b0; ser_data = 1'b0;
        zero_counts();
        #12;
        check("reset word",      {56'd0, word_m}, 64'd0);
        check("reset word_en",   {63'd0, word_en_m}, 64'd0);
        check("reset busy",      {63'd0, busy_m}, 64'd0);
        check("reset frame_err", {63'd0, frame_err_m}, 64'd0);
        check("reset parity",    {63'd0, parity_err_m}, 64'd0);
        resetN = 1'b1;
        step();

        // Table: full frames, some with gaps, some back-to-back
        for (int v = 0; v < 6; v++) begin
            logic [7:0] held;
            zero_counts();
            send_frame(vecs[v].bits, vecs[v].gap_max, 1'b1);
            check($sformatf("v%0d word_en latency", v), {63'd0, word_en_m}, 64'd1);
            check($sformatf("v%0d busy low", v), {63'd0, busy_m}, 64'd0);
            check($sformatf("v%0d word msb", v), {56'd0, word_m}, {56'd0, vecs[v].exp_m});
            check($sformatf("v%0d word lsb", v), {56'd0, word_l}, {56'd0, vecs[v].exp_l});
            check($sformatf("v%0d en count msb", v), 64'(en_m), 64'd1);
            check($sformatf("v%0d en count lsb", v), 64'(en_l), 64'd1);
            check($sformatf("v%0d no frame_err", v), 64'(ferr_m), 64'd0);
            if (vecs[v].idle_after) begin
                held = word_m;
                step();
                check($sformatf("v%0d word_en one cycle", v), {63'd0, word_en_m}, 64'd0);
                check($sformatf("v%0d word held", v), {56'd0, word_m}, {56'd0, held});
            end
        end

        // frame_start after 5 bits aborts; old word held until the new frame lands
        zero_counts();
        send_bits(9'h015, 5, 0, 1'b1);
        check("abort old word held", {56'd0, word_m}, 64'hFE);
        check("abort busy", {63'd0, busy_m}, 64'd1);
        zero_counts();
        send_frame(8'h3C, 1, 1'b1);
        check("abort frame_err msb", 64'(ferr_m), 64'd1);
        check("abort frame_err lsb", 64'(ferr_l), 64'd1);
        check("abort en count", 64'(en_m), 64'd1);
        check("abort new word msb", {56'd0, word_m}, 64'h3C);
        check("abort new word lsb", {56'd0, word_l}, 64'h3C);
        step();

        // frame_start coincident with the final data bit: frame_start wins
        zero_counts();
        send_bits(9'h07F, 7, 0, 1'b1);
        frame_start = 1'b1; ser_valid = 1'b1; ser_data = 1'b1;
        step();
        frame_start = 1'b0; ser_valid = 1'b0;
        check("collide frame_err", {63'd0, frame_err_m}, 64'd1);
        check("collide no word_en", 64'(en_m), 64'd0);
        check("collide busy", {63'd0, busy_m}, 64'd1);
        check("collide word held", {56'd0, word_m}, 64'h3C);
        zero_counts();
        send_frame(8'h66, 0, 1'b0);
        check("restart word", {56'd0, word_m}, 64'h66);
        check("restart en count", 64'(en_m), 64'd1);
        step();

        // Asynchronous reset mid-frame
        send_bits(9'h00A, 4, 0, 1'b1);
        #2;
        resetN = 1'b0;
        #1;
        check("async rst word", {56'd0, word_m}, 64'd0);
        check("async rst busy", {63'd0, busy_m}, 64'd0);
        check("async rst word_en", {63'd0, word_en_m}, 64'd0);
        step();
        resetN = 1'b1;
        zero_counts();
        send_frame(8'hFF, 0, 1'b1);
        check("post rst word", {56'd0, word_m}, 64'hFF);
        check("post rst en count", 64'(en_m), 64'd1);
        step();

        // sync_clear mid-frame, then data without frame_start is ignored
        zero_counts();
        send_bits(9'h02D, 6, 0, 1'b1);
        sync_clear = 1'b1;
        step();
        sync_clear = 1'b0;
        check("clear busy", {63'd0, busy_m}, 64'd0);
        check("clear no strobes", 64'(en_m + ferr_m + perr_m), 64'd0);
        check("clear word held", {56'd0, word_m}, 64'hFF);
        send_frame(8'hAA, 0, 1'b0);
        step();
        check("idle ignores bits", 64'(en_m), 64'd0);
        check("idle busy", {63'd0, busy_m}, 64'd0);
        zero_counts();
        send_frame(8'h81, 2, 1'b1);
        check("after clear word", {56'd0, word_m}, 64'h81);
        check("after clear en count", 64'(en_m), 64'd1);
        step();

`ifdef SERIAL_WORD_LOADER_PARITY_EN
        zero_counts();
        send_bits({8'h0F, 1'b0}, 9, 0, 1'b1);
        check("parity ok en", 64'(en_m), 64'd1);
        check("parity ok word", {56'd0, word_m}, 64'h0F);
        check("parity ok no err", 64'(perr_m), 64'd0);
        step();
        zero_counts();
        send_bits({8'h0F, 1'b1}, 9, 0, 1'b1);
        check("parity bad err", {63'd0, parity_err_m}, 64'd1);
        check("parity bad no en", 64'(en_m), 64'd0);
        check("parity bad word held", {56'd0, word_m}, 64'h0F);
        step();
        check("parity err one cycle", 64'(perr_m), 64'd1);
`else
        check("parity tied low", {63'd0, parity_err_m | parity_err_l}, 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
